// File: rtl/ll_reservation_table.sv
// ll_reservation_table: per-context LL/SC reservation tracker with granule address check and optional expiry
module ll_reservation_table #(
  parameter int NUM_CTX = 2,
  parameter int ADDR_W = 32,
  parameter int GRAN_LSB = 2,
  parameter int TIMEOUT = 0,
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ll_valid_i,
  input  logic [CTX_W-1:0]   ll_ctx_i,
  input  logic [ADDR_W-1:0]  ll_addr_i,
  input  logic               sc_valid_i,
  input  logic [CTX_W-1:0]   sc_ctx_i,
  input  logic [ADDR_W-1:0]  sc_addr_i,
  input  logic               st_valid_i,
  input  logic [ADDR_W-1:0]  st_addr_i,
  input  logic               exc_flg_i,
  input  logic [CTX_W-1:0]   exc_ctx_i,
  input  logic               clr_all_i,
  output logic               sc_resp_valid_o,
  output logic               sc_success_o,
  output logic [NUM_CTX-1:0] atomicbit_o
);
  localparam int TAG_W = ADDR_W - GRAN_LSB;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  logic [NUM_CTX-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [NUM_CTX];
  logic [TAG_W-1:0]   tag_d [NUM_CTX];
  logic [15:0]        cnt_q [NUM_CTX];
  logic [15:0]        cnt_d [NUM_CTX];
  logic               resp_q, succ_q;
  logic [TAG_W-1:0]   ll_tag, sc_tag, st_tag;
  logic               sc_ctx_ok, sc_ok;
  logic               unused_lsb;
  assign ll_tag = ll_addr_i[ADDR_W-1:GRAN_LSB];
  assign sc_tag = sc_addr_i[ADDR_W-1:GRAN_LSB];
  assign st_tag = st_addr_i[ADDR_W-1:GRAN_LSB];
  assign unused_lsb = ^{ll_addr_i, sc_addr_i, st_addr_i};
  assign sc_ctx_ok = int'(sc_ctx_i) < NUM_CTX;
  // SC verdict uses pre-edge state; any same-cycle kill of the target reservation makes it fail
  assign sc_ok = sc_valid_i && sc_ctx_ok && valid_q[sc_ctx_i] && tag_q[sc_ctx_i] == sc_tag &&
                 !clr_all_i && !(exc_flg_i && exc_ctx_i == sc_ctx_i) && !(st_valid_i && st_tag == sc_tag);
  // Per-entry next state in priority order: global clear, exception, LL, own SC, snooped write, expiry
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (clr_all_i || (exc_flg_i && exc_ctx_i == CTX_W'(i)))
        valid_d[i] = 1'b0;
      else if (ll_valid_i && ll_ctx_i == CTX_W'(i)) begin
        valid_d[i] = 1'b1;
        tag_d[i] = ll_tag;
        cnt_d[i] = '0;
      end else if ((sc_valid_i && sc_ctx_i == CTX_W'(i)) || (st_valid_i && st_tag == tag_q[i]) ||
                   (sc_ok && sc_tag == tag_q[i]))
        valid_d[i] = 1'b0;
      else if (valid_q[i]) begin
        if (TIMEOUT != 0 && cnt_q[i] == LAST)
          valid_d[i] = 1'b0;
        else if (cnt_q[i] != 16'hFFFF)
          cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end
  // State and registered SC response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      tag_q <= '{default: '0};
      cnt_q <= '{default: '0};
      resp_q <= 1'b0;
      succ_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      resp_q <= sc_valid_i;
      succ_q <= sc_ok;
    end
  end
  assign sc_resp_valid_o = resp_q;
  assign sc_success_o = succ_q;
  assign atomicbit_o = valid_q;
endmodule

// File: tb/tb_ll_reservation_table.sv
// tb_ll_reservation_table: table vectors, hand sequences and random traffic against a timestamp reference model
module tb_ll_reservation_table;
  localparam bit N = 1'b0, Y = 1'b1;
  logic clk = 1'b0, rst = 1'b0;
  logic ll_v = 1'b0, sc_v = 1'b0, st_v = 1'b0, exc_v = 1'b0, clr = 1'b0;
  logic [0:0] ll_c = '0, sc_c = '0, exc_c = '0;
  logic [31:0] ll_a = '0, sc_a = '0, st_a = '0;
  logic [1:0] a0, a4;
  logic r0, s0, r4, s4;
  int errs = 0, checks = 0, k = 0;
  bit mv [2][2];
  int unsigned mtag [2][2];
  int mset [2][2];
  bit mr [2], ms [2];
  int tmo [2] = '{0, 4};
  typedef struct {
    bit ll; bit llc; logic [31:0] lla;
    bit sc; bit scc; logic [31:0] sca;
    bit st; logic [31:0] sta;
    bit exc; bit excc; bit clr;
    logic [1:0] ea; bit er; bit es;
  } vec_t;
  vec_t tbl [25];

  ll_reservation_table #(.NUM_CTX(2), .ADDR_W(32), .GRAN_LSB(2), .TIMEOUT(0)) u0 (
    .clk(clk), .rst(rst), .ll_valid_i(ll_v), .ll_ctx_i(ll_c), .ll_addr_i(ll_a),
    .sc_valid_i(sc_v), .sc_ctx_i(sc_c), .sc_addr_i(sc_a), .st_valid_i(st_v), .st_addr_i(st_a),
    .exc_flg_i(exc_v), .exc_ctx_i(exc_c), .clr_all_i(clr),
    .sc_resp_valid_o(r0), .sc_success_o(s0), .atomicbit_o(a0));
  ll_reservation_table #(.NUM_CTX(2), .ADDR_W(32), .GRAN_LSB(2), .TIMEOUT(4)) u4 (
    .clk(clk), .rst(rst), .ll_valid_i(ll_v), .ll_ctx_i(ll_c), .ll_addr_i(ll_a),
    .sc_valid_i(sc_v), .sc_ctx_i(sc_c), .sc_addr_i(sc_a), .st_valid_i(st_v), .st_addr_i(st_a),
    .exc_flg_i(exc_v), .exc_ctx_i(exc_c), .clr_all_i(clr),
    .sc_resp_valid_o(r4), .sc_success_o(s4), .atomicbit_o(a4));

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned g(input logic [31:0] a);
    return a >> 2;
  endfunction

  // A reservation set at edge s is alive before edge k while k-s <= T and after edge k while k-s < T
  task automatic model_edge(input int m);
    bit lv [2];
    bit ok;
    for (int c = 0; c < 2; c++) lv[c] = mv[m][c] && (tmo[m] == 0 || k - mset[m][c] <= tmo[m]);
    ok = sc_v && lv[sc_c] && g(sc_a) == mtag[m][sc_c] && !clr && !(exc_v && exc_c == sc_c) &&
         !(st_v && g(st_a) == g(sc_a));
    for (int c = 0; c < 2; c++) begin
      if (clr || (exc_v && int'(exc_c) == c)) mv[m][c] = 0;
      else if (ll_v && int'(ll_c) == c) begin
        mv[m][c] = 1;
        mtag[m][c] = g(ll_a);
        mset[m][c] = k;
      end else if ((sc_v && int'(sc_c) == c) || (st_v && g(st_a) == mtag[m][c]) || (ok && g(sc_a) == mtag[m][c]))
        mv[m][c] = 0;
      else mv[m][c] = lv[c] && (tmo[m] == 0 || k - mset[m][c] < tmo[m]);
    end
    mr[m] = sc_v;
    ms[m] = ok;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = '{0, 0};
      mr[m] = 0;
      ms[m] = 0;
    end
  endtask

  task automatic step(input bit ll, input bit llc, input logic [31:0] lla,
                      input bit sc, input bit scc, input logic [31:0] sca,
                      input bit st, input logic [31:0] sta,
                      input bit exc, input bit excc, input bit cl);
    ll_v = ll; ll_c = llc; ll_a = lla;
    sc_v = sc; sc_c = scc; sc_a = sca;
    st_v = st; st_a = sta;
    exc_v = exc; exc_c = excc; clr = cl;
    @(posedge clk);
    k++;
    model_edge(0);
    model_edge(1);
    #1;
    chk("model_atom_t0", 32'(a0), 32'({mv[0][1], mv[0][0]}));
    chk("model_resp_t0", 32'(r0), 32'(mr[0]));
    chk("model_succ_t0", 32'(s0), 32'(ms[0]));
    chk("model_atom_t4", 32'(a4), 32'({mv[1][1], mv[1][0]}));
    chk("model_resp_t4", 32'(r4), 32'(mr[1]));
    chk("model_succ_t4", 32'(s4), 32'(ms[1]));
    ll_v = 0; sc_v = 0; st_v = 0; exc_v = 0; clr = 0;
  endtask

  task automatic idle();
    step(N, N, '0, N, N, '0, N, '0, N, N, N);
  endtask

  function automatic logic [31:0] ra();
    return 32'h1000 + 32'($urandom_range(0, 15));
  endfunction

  initial begin
    tbl = '{
      '{Y, N, 32'h1000, N, N, '0,        N, '0,       N, N, N, 2'b01, N, N},
      '{N, N, '0,       N, N, '0,        N, '0,       N, N, N, 2'b01, N, N},
      '{N, N, '0,       Y, N, 32'h1003,  N, '0,       N, N, N, 2'b00, Y, Y},
      '{Y, N, 32'h1000, N, N, '0,        N, '0,       N, N, N, 2'b01, N, N},
      '{N, N, '0,       N, N, '0,        N, '0,       N, N, N, 2'b01, N, N},
      '{N, N, '0,       Y, N, 32'h1004,  N, '0,       N, N, N, 2'b00, Y, N},
      '{Y, N, 32'h2000, N, N, '0,        N, '0,       N, N, N, 2'b01, N, N},
      '{Y, Y, 32'h2000, N, N, '0,        N, '0,       N, N, N, 2'b11, N, N},
      '{N, N, '0,       Y, Y, 32'h2000,  N, '0,       N, N, N, 2'b00, Y, Y},
      '{N, N, '0,       Y, N, 32'h2000,  N, '0,       N, N, N, 2'b00, Y, N},
      '{Y, N, 32'h3000, N, N, '0,        N, '0,       N, N, N, 2'b01, N, N},
      '{N, N, '0,       N, N, '0,        Y, 32'h3004, N, N, N, 2'b01, N, N},
      '{N, N, '0,       N, N, '0,        Y, 32'h3000, N, N, N, 2'b00, N, N},
      '{Y, Y, 32'h4000, N, N, '0,        N, '0,       N, N, N, 2'b10, N, N},
      '{N, N, '0,       Y, Y, 32'h4000,  N, '0,       Y, Y, N, 2'b00, Y, N},
      '{Y, N, 32'h5000, N, N, '0,        N, '0,       N, N, Y, 2'b00, N, N},
      '{Y, N, 32'h5000, N, N, '0,        Y, 32'h5000, N, N, N, 2'b01, N, N},
      '{N, N, '0,       Y, N, 32'h5000,  Y, 32'h5000, N, N, N, 2'b00, Y, N},
      '{Y, N, 32'h6000, N, N, '0,        N, '0,       N, N, N, 2'b01, N, N},
      '{Y, N, 32'h6000, Y, N, 32'h6000,  N, '0,       N, N, N, 2'b01, Y, Y},
      '{N, N, '0,       Y, N, 32'h6000,  N, '0,       N, N, N, 2'b00, Y, Y},
      '{N, N, '0,       N, N, '0,        N, '0,       N, N, N, 2'b00, N, N},
      '{Y, Y, 32'h7000, N, N, '0,        N, '0,       N, N, N, 2'b10, N, N},
      '{N, N, '0,       N, N, '0,        N, '0,       Y, N, N, 2'b10, N, N},
      '{N, N, '0,       Y, Y, 32'h7000,  N, '0,       Y, N, N, 2'b00, Y, Y}
    };
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_atom_t0", 32'(a0), 32'h0);
    chk("reset_resp_t0", 32'(r0), 32'h0);
    chk("reset_succ_t0", 32'(s0), 32'h0);
    chk("reset_atom_t4", 32'(a4), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].ll, tbl[i].llc, tbl[i].lla, tbl[i].sc, tbl[i].scc, tbl[i].sca,
           tbl[i].st, tbl[i].sta, tbl[i].exc, tbl[i].excc, tbl[i].clr);
      chk($sformatf("tbl%0d_atom", i), 32'(a0), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d_resp", i), 32'(r0), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_succ", i), 32'(s0), 32'(tbl[i].es));
    end
    step(Y, N, 32'h1000, Y, Y, 32'h1000, N, '0, N, N, N);
    chk("pre_rst_atom", 32'(a0), 32'h1);
    chk("pre_rst_resp", 32'(r0), 32'h1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_atom_t0", 32'(a0), 32'h0);
    chk("mid_rst_resp_t0", 32'(r0), 32'h0);
    chk("mid_rst_atom_t4", 32'(a4), 32'h0);
    chk("mid_rst_resp_t4", 32'(r4), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(N, N, '0, Y, N, 32'h1000, N, '0, N, N, N);
    chk("post_rst_resp", 32'(r0), 32'h1);
    chk("post_rst_succ", 32'(s0), 32'h0);
    step(Y, N, 32'h8000, N, N, '0, N, '0, N, N, N);
    chk("to_live_1", 32'(a4[0]), 32'h1);
    for (int i = 2; i <= 4; i++) begin
      idle();
      chk($sformatf("to_live_%0d", i), 32'(a4[0]), 32'h1);
    end
    idle();
    chk("to_expired", 32'(a4[0]), 32'h0);
    chk("to_never_t0", 32'(a0[0]), 32'h1);
    step(Y, N, 32'h8000, N, N, '0, N, '0, N, N, N);
    repeat (3) idle();
    step(N, N, '0, Y, N, 32'h8000, N, '0, N, N, N);
    chk("to_sc_last_cycle", 32'(s4), 32'h1);
    step(Y, N, 32'h8000, N, N, '0, N, '0, N, N, N);
    repeat (4) idle();
    step(N, N, '0, Y, N, 32'h8000, N, '0, N, N, N);
    chk("to_sc_expired_t4", 32'(s4), 32'h0);
    chk("to_sc_alive_t0", 32'(s0), 32'h1);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)), ra(),
           $urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)), ra(),
           $urandom_range(0, 99) < 15, ra(),
           $urandom_range(0, 99) < 8, 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ll_reservation_table.md
# ll_reservation_table

Parametrised load-linked/store-conditional reservation tracker for the MIPS core. It holds one reservation per hardware context: a valid bit, a granule-aligned address tag and an expiry counter. It sits beside the memory stage. LL instructions set a reservation, SC instructions consume it and get a registered pass/fail response, and ordinary stores, exceptions, ERET/flush and timeouts clear it. Reservations are address-checked and per-context, which the old single atomic bit could not do.

## Interface
Parameters:
- NUM_CTX, 2, number of hardware contexts (≥1); CTX_W = max(1, $clog2(NUM_CTX))
- ADDR_W, 32, physical address width
- GRAN_LSB, 2, address bits [GRAN_LSB-1:0] ignored in all compares (reservation granule = 2^GRAN_LSB bytes)
- TIMEOUT, 0, cycles a reservation lives after being set; 0 disables expiry; legal range 0..65535

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ll_valid_i  in  1  LL executes this cycle
- ll_ctx_i  in  CTX_W  context issuing LL
- ll_addr_i  in  ADDR_W  LL address
- sc_valid_i  in  1  SC executes this cycle
- sc_ctx_i  in  CTX_W  context issuing SC
- sc_addr_i  in  ADDR_W  SC address
- st_valid_i  in  1  ordinary store commits this cycle
- st_addr_i  in  ADDR_W  store address
- exc_flg_i  in  1  exception taken this cycle
- exc_ctx_i  in  CTX_W  context taking the exception
- clr_all_i  in  1  ERET / cache flush, kills every reservation
- sc_resp_valid_o  out  1  SC result valid, registered
- sc_success_o  out  1  1 = SC succeeded, meaningful only when sc_resp_valid_o=1
- atomicbit_o  out  NUM_CTX  per-context reservation valid bits, registered

## Operation
Per-entry state: valid, tag[ADDR_W-1:GRAN_LSB], cnt[15:0]. "Match" means equal address bits [ADDR_W-1:GRAN_LSB].

The SC verdict is computed from the pre-edge state. It succeeds only if all of these hold:
- entry[sc_ctx_i].valid = 1
- tag matches sc_addr_i
- no clr_all_i in the same cycle
- no exc_flg_i with exc_ctx_i = sc_ctx_i in the same cycle
- no st_valid_i with a matching st_addr_i in the same cycle

Any other case fails.

Next-state of entry i, highest priority first:
1. clr_all_i → valid=0.
2. exc_flg_i && exc_ctx_i==i → valid=0.
3. ll_valid_i && ll_ctx_i==i → valid=1, tag=ll_addr_i granule, cnt=0. This overrides rules 4–6 in the same cycle.
4. sc_valid_i && sc_ctx_i==i → valid=0, whether the SC passes or fails.
5. Kill on a matching write to tag[i] from either source:
   - st_valid_i with matching st_addr_i, or
   - a successful SC from another context with matching sc_addr_i.
   Either → valid=0. The write's own context is included for ordinary stores.
6. TIMEOUT≠0, valid=1 and cnt==TIMEOUT-1 → valid=0. Otherwise, if valid, cnt increments (saturating at 0xFFFF).

Other rules:
- An invalid entry keeps its tag and cnt; neither is observable.
- An LL to a context that already holds a reservation replaces it with a new tag and cnt=0.
- ll_ctx_i, sc_ctx_i, exc_ctx_i ≥ NUM_CTX: the request is ignored, and an SC with such a context responds with fail.

## Timing
- Reset (rst=0, async): all valid=0, cnt=0, atomicbit_o=0, sc_resp_valid_o=0, sc_success_o=0. Release is synchronous to the next clk edge.
- LL in cycle N → atomicbit_o[ctx]=1 from cycle N+1.
- SC in cycle N → sc_resp_valid_o=1 and sc_success_o in cycle N+1 only. Back-to-back SCs give back-to-back responses. With no SC, sc_resp_valid_o=0 and sc_success_o=0.
- LL and SC from the same context in one cycle: the SC is judged on the old state, then the LL sets a fresh reservation, so atomicbit_o[ctx]=1 next cycle.
- Clears from exc/clr_all/store/SC in cycle N → atomicbit_o bit low in cycle N+1.
- TIMEOUT=T: an LL in cycle N leaves the bit high for cycles N+1..N+T, and it is low from N+T+1.
- No backpressure; every request is accepted in the cycle it is presented.

## Test plan
- Reset mid-operation: LL ctx0 0x1000, assert rst low between edges → atomicbit_o=0 and sc_resp_valid_o=0 immediately. After release, SC ctx0 0x1000 → success=0.
- Basic pair, NUM_CTX=2, GRAN_LSB=2: LL ctx0 0x1000, SC ctx0 0x1003 two cycles later → next cycle resp_valid=1, success=1, atomicbit_o=2'b00. Repeat with SC 0x1004 → success=0.
- Cross-context kill: LL ctx0 0x2000, LL ctx1 0x2000, SC ctx1 0x2000 → success=1, atomicbit_o=2'b00 (ctx0 killed). A second SC ctx0 0x2000 → success=0.
- Snoop and exception:
  - LL ctx0 0x3000, then a store to 0x3004 → atomicbit_o[0] stays 1.
  - A store to 0x3000 → bit 0 clears.
  - LL ctx1 0x4000, then exc_flg_i with ctx1 in the same cycle as SC ctx1 0x4000 → success=0.
- Simultaneous events:
  - LL ctx0 0x5000 with clr_all_i in the same cycle → atomicbit_o[0]=0.
  - LL ctx0 0x5000 with a matching store in the same cycle → atomicbit_o[0]=1.
  - SC ctx0 0x5000 with a matching store in the same cycle → success=0.
- Timeout, TIMEOUT=4: LL ctx0 in cycle 10 → atomicbit_o[0] high for cycles 11–14 and low at 15. An SC in cycle 14 → success=1. An SC in cycle 15 → success=0.
